// File: rtl/tracker_pkg.sv
// Shared state encoding and default widths for the object tracker slice.
package tracker_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    ACCUM,
    HOLD
  } state_e;

  localparam int unsigned X_W_DEF        = 10;
  localparam int unsigned Y_W_DEF        = 10;
  localparam int unsigned CNT_W_DEF      = 19;
  localparam int unsigned MIN_PIXELS_DEF = 16;

endpackage

// File: rtl/bbox_accum.sv
// Bounding-box and object-pixel count accumulator; clr_i dominates hit_i.
module bbox_accum
  import tracker_pkg::*;
#(
  parameter int unsigned X_W   = X_W_DEF,
  parameter int unsigned Y_W   = Y_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             hit_i,
  input  logic [X_W-1:0]   x_i,
  input  logic [Y_W-1:0]   y_i,
  output logic [X_W-1:0]   min_x_o,
  output logic [X_W-1:0]   max_x_o,
  output logic [Y_W-1:0]   min_y_o,
  output logic [Y_W-1:0]   max_y_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [X_W-1:0]   min_x_q, min_x_d, max_x_q, max_x_d;
  logic [Y_W-1:0]   min_y_q, min_y_d, max_y_q, max_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    min_x_d = min_x_q;
    max_x_d = max_x_q;
    min_y_d = min_y_q;
    max_y_d = max_y_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      min_x_d = '1;
      max_x_d = '0;
      min_y_d = '1;
      max_y_d = '0;
      cnt_d   = '0;
    end else if (hit_i) begin
      if (x_i < min_x_q) min_x_d = x_i;
      if (x_i > max_x_q) max_x_d = x_i;
      if (y_i < min_y_q) min_y_d = y_i;
      if (y_i > max_y_q) max_y_d = y_i;
      // Saturate rather than wrap so an oversized blob still reads as found.
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_x_q <= '1;
      max_x_q <= '0;
      min_y_q <= '1;
      max_y_q <= '0;
      cnt_q   <= '0;
    end else begin
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
      cnt_q   <= cnt_d;
    end
  end

  assign min_x_o = min_x_q;
  assign max_x_o = max_x_q;
  assign min_y_o = min_y_q;
  assign max_y_o = max_y_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/object_track_ctrl.sv
// Frame sequencer: arms on start/continuous, accumulates one frame's object bbox,
// then holds a result record until the consumer handshakes it.
module object_track_ctrl
  import tracker_pkg::*;
#(
  parameter int unsigned X_W        = X_W_DEF,
  parameter int unsigned Y_W        = Y_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned MIN_PIXELS = MIN_PIXELS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             continuous,
  input  logic             start,
  input  logic             object_pixel,
  input  logic [X_W-1:0]   x,
  input  logic [Y_W-1:0]   y,
  input  logic             pixel_valid,
  input  logic             frame_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic             result_valid,
  output logic [X_W-1:0]   bbox_x_min,
  output logic [X_W-1:0]   bbox_x_max,
  output logic [Y_W-1:0]   bbox_y_min,
  output logic [Y_W-1:0]   bbox_y_max,
  output logic [X_W-1:0]   center_x,
  output logic [Y_W-1:0]   center_y,
  output logic [CNT_W-1:0] pixel_count,
  output logic             object_found,
  output logic             overrun,
  output logic [15:0]      frame_count
);

  typedef struct packed {
    logic [X_W-1:0]   xmin;
    logic [X_W-1:0]   xmax;
    logic [Y_W-1:0]   ymin;
    logic [Y_W-1:0]   ymax;
    logic [X_W-1:0]   cx;
    logic [Y_W-1:0]   cy;
    logic [CNT_W-1:0] cnt;
    logic             found;
  } result_t;

  state_e  state_q, state_d;
  result_t res_q, res_d;
  logic    fv_d_q;
  logic    ovr_q, ovr_d;
  logic [15:0] fc_q, fc_d;

  logic sof, eof, hit, acc_en, load, ovr_set, found;
  logic [X_W-1:0]   acc_min_x, acc_max_x;
  logic [Y_W-1:0]   acc_min_y, acc_max_y;
  logic [CNT_W-1:0] acc_cnt;

  assign sof = frame_valid & ~fv_d_q;
  assign eof = ~frame_valid & fv_d_q;
  assign hit = pixel_valid & frame_valid & object_pixel;

  bbox_accum #(
    .X_W   (X_W),
    .Y_W   (Y_W),
    .CNT_W (CNT_W)
  ) u_accum (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (~acc_en),
    .hit_i   (hit),
    .x_i     (x),
    .y_i     (y),
    .min_x_o (acc_min_x),
    .max_x_o (acc_max_x),
    .min_y_o (acc_min_y),
    .max_y_o (acc_max_y),
    .cnt_o   (acc_cnt)
  );

  // Accumulation is also enabled in the SOF cycle of WAIT_SOF so a hit there counts.
  always_comb begin
    state_d = state_q;
    acc_en  = 1'b0;
    load    = 1'b0;
    ovr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start | continuous) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (sof) begin
          state_d = ACCUM;
          acc_en  = 1'b1;
        end
      end
      ACCUM: begin
        acc_en = 1'b1;
        if (eof) begin
          state_d = HOLD;
          load    = 1'b1;
        end
      end
      HOLD: begin
        ovr_set = sof;
        if (result_ready) state_d = continuous ? WAIT_SOF : IDLE;
      end
    endcase
    if (!enable) begin
      state_d = IDLE;
      acc_en  = 1'b0;
      load    = 1'b0;
    end
  end

  assign found = acc_cnt >= CNT_W'(MIN_PIXELS);

  always_comb begin
    res_d = res_q;
    if (load) begin
      res_d.cnt   = acc_cnt;
      res_d.found = found;
      res_d.xmin  = found ? acc_min_x : '0;
      res_d.xmax  = found ? acc_max_x : '0;
      res_d.ymin  = found ? acc_min_y : '0;
      res_d.ymax  = found ? acc_max_y : '0;
      res_d.cx    = found ? X_W'(({1'b0, acc_min_x} + {1'b0, acc_max_x}) >> 1) : '0;
      res_d.cy    = found ? Y_W'(({1'b0, acc_min_y} + {1'b0, acc_max_y}) >> 1) : '0;
    end
  end

  always_comb begin
    ovr_d = ovr_q;
    if (state_q == IDLE && start) ovr_d = 1'b0;
    if (ovr_set) ovr_d = 1'b1;
    fc_d = fc_q + 16'(load);
  end

  // fv_d_q resets high so a reset in mid-frame cannot fake a start of frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      fv_d_q  <= 1'b1;
      ovr_q   <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      fv_d_q  <= frame_valid;
      ovr_q   <= ovr_d;
      fc_q    <= fc_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == HOLD);
  assign bbox_x_min   = res_q.xmin;
  assign bbox_x_max   = res_q.xmax;
  assign bbox_y_min   = res_q.ymin;
  assign bbox_y_max   = res_q.ymax;
  assign center_x     = res_q.cx;
  assign center_y     = res_q.cy;
  assign pixel_count  = res_q.cnt;
  assign object_found = res_q.found;
  assign overrun      = ovr_q;
  assign frame_count  = fc_q;

endmodule
